// File: rtl/dispatch_pkg.sv
// ----------------------------------------------------------------------------
// dispatch_pkg
//   Shared types and constants for the dispatch buffer and the issue queue.
//   The dispatch_uop_t field layout is consumed bit-for-bit by the issue
//   queue, so field order and widths must not change independently.
// ----------------------------------------------------------------------------
package dispatch_pkg;

    localparam int LANES  = 8;
    localparam int PTAG_W = 7;
    localparam int XLEN   = 64;
    localparam int ROB_W  = 8;
    localparam int UOP_W  = 298;

    typedef enum logic [2:0] {
        FT_INT = 3'd0,
        FT_MUL = 3'd1,
        FT_VEC = 3'd2,
        FT_MEM = 3'd3,
        FT_BR  = 3'd4
    } func_type_e;

    typedef struct packed {
        func_type_e              func_type;
        logic [XLEN-1:0]         op1;
        logic [XLEN-1:0]         op2;
        logic [XLEN-1:0]         op3;
        logic [XLEN-1:0]         pred_mask;
        logic [PTAG_W-1:0]       src1_tag;
        logic [PTAG_W-1:0]       src2_tag;
        logic [PTAG_W-1:0]       src3_tag;
        logic [PTAG_W-1:0]       dest;
        logic [ROB_W-1:0]        rob_idx;
        logic                    rdy1;
        logic                    rdy2;
        logic                    rdy3;
    } dispatch_uop_t;

endpackage

// File: rtl/dispatch_buffer_8wide_wakeup_snoop.sv
// ----------------------------------------------------------------------------
// wakeup_snoop
//   Purely combinational operand wakeup for one uop. For each source operand
//   that is not yet ready, a valid wakeup lane with a matching tag marks it
//   ready and supplies the data. When several lanes match, the lowest lane
//   index wins. Operands already ready are passed through untouched.
// Ports
//   uop_i           uop before wakeup
//   wakeup_valid_i  per-lane broadcast valid
//   wakeup_tag_i    per-lane physical tag
//   wakeup_data_i   per-lane result data
//   uop_o           uop after wakeup
// ----------------------------------------------------------------------------
module wakeup_snoop
    import dispatch_pkg::*;
(
    input  dispatch_uop_t                      uop_i,
    input  logic [LANES-1:0]                   wakeup_valid_i,
    input  logic [LANES-1:0][PTAG_W-1:0]       wakeup_tag_i,
    input  logic [LANES-1:0][XLEN-1:0]         wakeup_data_i,
    output dispatch_uop_t                      uop_o
);

    always_comb begin
        uop_o = uop_i;
        // Walk from the highest lane down so the lowest matching lane is the
        // last writer and therefore wins.
        for (int w = LANES - 1; w >= 0; w--) begin
            if (wakeup_valid_i[w]) begin
                if (!uop_i.rdy1 && (wakeup_tag_i[w] == uop_i.src1_tag)) begin
                    uop_o.rdy1 = 1'b1;
                    uop_o.op1  = wakeup_data_i[w];
                end
                if (!uop_i.rdy2 && (wakeup_tag_i[w] == uop_i.src2_tag)) begin
                    uop_o.rdy2 = 1'b1;
                    uop_o.op2  = wakeup_data_i[w];
                end
                if (!uop_i.rdy3 && (wakeup_tag_i[w] == uop_i.src3_tag)) begin
                    uop_o.rdy3 = 1'b1;
                    uop_o.op3  = wakeup_data_i[w];
                end
            end
        end
    end

endmodule

// File: rtl/dispatch_buffer_8wide.sv
// ----------------------------------------------------------------------------
// dispatch_buffer_8wide
//   Elastic circular buffer between rename/dispatch and the issue queue.
//   Accepts up to LANES uops per cycle (gaps squeezed out, program order kept),
//   offers the LANES oldest uops to the issue queue each cycle, and keeps the
//   operand-ready state of every buffered and incoming uop current by snooping
//   wakeup broadcasts. Outputs reflect the current cycle's wakeups.
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   flush_i           drop every buffered uop; blocks enqueue and alloc
//   in_valid_i/in_uop_i   per-lane uops from rename
//   in_ready_o        room for a full group of LANES uops
//   iq_full_i         issue queue cannot allocate this cycle
//   out_valid_o/out_uop_o oldest uops offered to the issue queue
//   wakeup_valid_i/tag_i/data_i  wakeup broadcast lanes
//   count_o, empty_o  occupancy
// ----------------------------------------------------------------------------
module dispatch_buffer_8wide
    import dispatch_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int LANES = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               flush_i,
    input  logic [LANES-1:0]                   in_valid_i,
    input  dispatch_uop_t [LANES-1:0]          in_uop_i,
    output logic                               in_ready_o,
    input  logic                               iq_full_i,
    output logic [LANES-1:0]                   out_valid_o,
    output dispatch_uop_t [LANES-1:0]          out_uop_o,
    input  logic [LANES-1:0]                   wakeup_valid_i,
    input  logic [LANES-1:0][PTAG_W-1:0]       wakeup_tag_i,
    input  logic [LANES-1:0][XLEN-1:0]         wakeup_data_i,
    output logic [$clog2(DEPTH+1)-1:0]         count_o,
    output logic                               empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int LCW   = $clog2(LANES + 1);

    dispatch_uop_t     entries_q [DEPTH];
    dispatch_uop_t     entries_d [DEPTH];
    dispatch_uop_t     entry_wk  [DEPTH];
    dispatch_uop_t     in_wk     [LANES];

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              enq;
    logic [LCW-1:0]    n_enq;
    logic [LCW-1:0]    n_deq;
    logic [PTR_W-1:0]  lane_off [LANES];

    // Wakeup snoop on every stored entry and every incoming lane.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry_snoop
        wakeup_snoop u_snoop (
            .uop_i          (entries_q[i]),
            .wakeup_valid_i (wakeup_valid_i),
            .wakeup_tag_i   (wakeup_tag_i),
            .wakeup_data_i  (wakeup_data_i),
            .uop_o          (entry_wk[i])
        );
    end

    for (genvar l = 0; l < LANES; l++) begin : g_in_snoop
        wakeup_snoop u_snoop (
            .uop_i          (in_uop_i[l]),
            .wakeup_valid_i (wakeup_valid_i),
            .wakeup_tag_i   (wakeup_tag_i),
            .wakeup_data_i  (wakeup_data_i),
            .uop_o          (in_wk[l])
        );
    end

    // Admission depends only on registered occupancy so rename never sees a
    // combinational path from the issue-queue side.
    assign in_ready_o = !flush_i && (count_q <= CNT_W'(DEPTH - LANES));
    assign enq        = in_ready_o && (|in_valid_i);
    assign count_o    = count_q;
    assign empty_o    = (count_q == '0);

    // Packing network: each valid lane lands at tail + (number of valid lanes
    // below it), which squeezes out gaps while preserving lane order.
    always_comb begin
        logic [LCW-1:0] acc;
        acc = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_off[l] = PTR_W'(acc);
            acc         = acc + LCW'(in_valid_i[l]);
        end
        n_enq = enq ? acc : '0;
    end

    // Alloc side: the LANES oldest entries, already carrying this cycle's
    // wakeups, with lane 0 the oldest.
    always_comb begin
        n_deq = '0;
        for (int k = 0; k < LANES; k++) begin
            out_uop_o[k]   = entry_wk[head_q + PTR_W'(k)];
            out_valid_o[k] = (CNT_W'(k) < count_q) && !iq_full_i && !flush_i;
            n_deq          = n_deq + LCW'(out_valid_o[k]);
        end
    end

    // Next-state: stored entries always absorb wakeups; enqueue writes on top.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            entries_d[i] = entry_wk[i];
        end
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            for (int l = 0; l < LANES; l++) begin
                if (enq && in_valid_i[l]) begin
                    entries_d[tail_q + lane_off[l]] = in_wk[l];
                end
            end
            head_d  = head_q + PTR_W'(n_deq);
            tail_d  = tail_q + PTR_W'(n_enq);
            count_d = count_q + CNT_W'(n_enq) - CNT_W'(n_deq);
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage; occupancy is tracked by count_q, so no reset needed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            entries_q[i] <= entries_d[i];
        end
    end

endmodule
